snn_windowed_core: RTL and testbench



---
 rtl/snn_windowed_core.sv | 261 ++++++++++++++++++++++++++
 tb/tb_snn_windowed_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_windowed_core.sv
// snn_windowed_core: two-layer spiking-network core with a fixed-length run window.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   data_in/data_valid byte load stream; data_ready = byte accepted this cycle
//   cmd                load target: 00 inputs, 01 weights, 10 config, 11 dropped
//   start              run request pulse (ignored while busy)
//   busy / done        run in progress / run finished, results held
//   spikes             raw output-layer spikes
//   count_sel          selects the spike counter shown on count_out (combinational mux)
//   winner             index of the largest spike count (lowest index on ties)
//
// Optional feature: define SNN_ARGMAX_EN to build the argmax winner logic;
// without it winner is tied to 0.
//
// Neuron model (leaky integrate-and-fire, 1-bit weights: 1 = +1, 0 = -1):
//   acc   = (mem >> shift) + sum_i(in_i ? w_i : 0)
//   fire  = acc >= threshold
//   mem'  = fire ? 0 : max(acc, 0);  spike register <= fire
module snn_windowed_core #(
  parameter int unsigned INPUTS     = 16,
  parameter int unsigned NEURONS_0  = 16,
  parameter int unsigned NEURONS_1  = 8,
  parameter int unsigned TIMESTEPS  = 8,
  parameter int unsigned COUNT_BITS = $clog2(TIMESTEPS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   data_in,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic [1:0]                   cmd,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [NEURONS_1-1:0]         spikes,
  input  logic [$clog2(NEURONS_1)-1:0] count_sel,
  output logic [COUNT_BITS-1:0]        count_out,
  output logic [$clog2(NEURONS_1)-1:0] winner
);

  localparam int unsigned SEL_W   = $clog2(NEURONS_1);
  localparam int unsigned STEP_W  = $clog2(TIMESTEPS + 1);
  localparam int unsigned W0_BITS = INPUTS * NEURONS_0;
  localparam int unsigned W_BITS  = W0_BITS + NEURONS_0 * NEURONS_1;
  localparam int unsigned MEM_W   = 8;
  localparam int unsigned ACC_W   = MEM_W + $clog2(INPUTS + NEURONS_0 + 1) + 1;
  localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [STEP_W-1:0]     step_q;
  logic [INPUTS-1:0]     in_q;
  logic [W_BITS-1:0]     w_q;
  logic [23:0]           cfg_q;
  logic [7:0]            thr0;
  logic [7:0]            thr1;
  logic [2:0]            shift;
  logic [COUNT_BITS-1:0] cnt_q   [NEURONS_1];
  logic [COUNT_BITS-1:0] cnt_nxt [NEURONS_1];
  logic [NEURONS_0-1:0]  spk0;
  logic [NEURONS_0-1:0]  pipe_q;
  logic                  accept;
  logic                  clear;
  logic                  en;
  logic                  last_step;

  assign thr0  = cfg_q[23:16];
  assign thr1  = cfg_q[15:8];
  assign shift = cfg_q[2:0];

  // start outranks a pending byte, so the port refuses it in that cycle
  assign data_ready = (state != S_RUN) && !start;
  assign accept     = data_valid && data_ready;
  assign clear      = start && (state != S_RUN);
  assign en         = (state == S_RUN);
  assign last_step  = en && (step_q == STEP_W'(TIMESTEPS));

  // Byte-stream load: each target is a shift register fed at the LSB end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q  <= '0;
      w_q   <= '1;
      cfg_q <= {8'd5, 8'd9, 8'd0};
    end else if (accept) begin
      case (cmd)
        2'b00:   in_q  <= INPUTS'({in_q, data_in});
        2'b01:   w_q   <= W_BITS'({w_q, data_in});
        2'b10:   cfg_q <= 24'({cfg_q, data_in});
        default: ;
      endcase
    end
  end

  // Run state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      step_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            step_q <= '0;
          end
        end
        S_RUN: begin
          if (last_step) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_DONE: begin
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
            step_q <= '0;
          end else if (accept) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Spike counters: step 0 only shows the cleared network, so it is not counted
  always_comb begin
    for (int j = 0; j < int'(NEURONS_1); j++) begin
      cnt_nxt[j] = cnt_q[j];
      if (en && (step_q != '0) && spikes[j] && (cnt_q[j] != '1)) begin
        cnt_nxt[j] = cnt_q[j] + COUNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int j = 0; j < int'(NEURONS_1); j++) cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < int'(NEURONS_1); j++) cnt_q[j] <= cnt_nxt[j];
    end
  end

  assign count_out = cnt_q[count_sel];

`ifdef SNN_ARGMAX_EN
  logic [SEL_W-1:0]      best_idx;
  logic [COUNT_BITS-1:0] best_cnt;

  // Argmax over the final counts (including the last step's increment)
  always_comb begin
    best_idx = '0;
    best_cnt = cnt_nxt[0];
    for (int j = 1; j < int'(NEURONS_1); j++) begin
      if (cnt_nxt[j] > best_cnt) begin
        best_cnt = cnt_nxt[j];
        best_idx = SEL_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      winner <= '0;
    end else if (last_step) begin
      winner <= best_idx;
    end
  end
`else
  assign winner = '0;
`endif

  // Hidden layer: one LIF neuron per output, all INPUTS synapses
  for (genvar n = 0; n < int'(NEURONS_0); n++) begin : g_lif0
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc;
    logic                    fire;
    logic [MEM_W-1:0]        mem_q;
    logic                    spk_q;

    always_comb begin
      sum = '0;
      for (int i = 0; i < int'(INPUTS); i++) begin
        if (in_q[i]) sum = w_q[n*INPUTS + i] ? sum + ONE : sum - ONE;
      end
      acc  = $signed(ACC_W'(mem_q >> shift)) + sum;
      fire = (acc >= $signed(ACC_W'(thr0)));
    end

    always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
        mem_q <= '0;
        spk_q <= 1'b0;
      end else if (en) begin
        spk_q <= fire;
        mem_q <= (fire || acc[ACC_W-1]) ? '0 : MEM_W'(acc);
      end
    end

    assign spk0[n] = spk_q;
  end

  // Hidden spikes are registered before feeding the output layer
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pipe_q <= '0;
    end else if (en) begin
      pipe_q <= spk0;
    end
  end

  // Output layer: one LIF neuron per output, NEURONS_0 synapses
  for (genvar m = 0; m < int'(NEURONS_1); m++) begin : g_lif1
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc;
    logic                    fire;
    logic [MEM_W-1:0]        mem_q;
    logic                    spk_q;

    always_comb begin
      sum = '0;
      for (int k = 0; k < int'(NEURONS_0); k++) begin
        if (pipe_q[k]) sum = w_q[W0_BITS + m*NEURONS_0 + k] ? sum + ONE : sum - ONE;
      end
      acc  = $signed(ACC_W'(mem_q >> shift)) + sum;
      fire = (acc >= $signed(ACC_W'(thr1)));
    end

    always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
        mem_q <= '0;
        spk_q <= 1'b0;
      end else if (en) begin
        spk_q <= fire;
        mem_q <= (fire || acc[ACC_W-1]) ? '0 : MEM_W'(acc);
      end
    end

    assign spikes[m] = spk_q;
  end

endmodule

// File: tb/tb_snn_windowed_core.sv
`timescale 1ns/1ps
module tb_snn_windowed_core;

  localparam int INPUTS = 16;
  localparam int N0     = 16;
  localparam int N1     = 8;
  localparam int T      = 8;
  localparam int CB     = 4;
  localparam int SW     = 3;
  localparam int WB     = INPUTS*N0 + N0*N1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [1:0]    cmd = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [N1-1:0] spikes;
  logic [SW-1:0] count_sel = '0;
  logic [CB-1:0] count_out;
  logic [SW-1:0] winner;

  snn_windowed_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .cmd        (cmd),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .spikes     (spikes),
    .count_sel  (count_sel),
    .count_out  (count_out),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // Reference state: the loadable registers as the specification describes them
  logic [INPUTS-1:0] m_in;
  logic [WB-1:0]     m_w;
  logic [23:0]       m_cfg;
  int                exp_cnt [N1];
  logic [N1-1:0]     exp_spk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_in  = '0;
    m_w   = '1;
    m_cfg = {8'd5, 8'd9, 8'd0};
  endtask

  // One run of TIMESTEPS+1 network updates; counts sample the output spikes of steps 1..T
  task automatic model_run();
    int v0 [N0];
    int v1 [N1];
    bit s0 [N0];
    bit p  [N0];
    bit s1 [N1];
    bit ns0 [N0];
    bit ns1 [N1];
    int th0, th1, sh, sum, a;
    th0 = int'(m_cfg[23:16]);
    th1 = int'(m_cfg[15:8]);
    sh  = int'(m_cfg[2:0]);
    for (int n = 0; n < N0; n++) begin v0[n] = 0; s0[n] = 0; p[n] = 0; end
    for (int j = 0; j < N1; j++) begin v1[j] = 0; s1[j] = 0; exp_cnt[j] = 0; end
    for (int s = 0; s <= T; s++) begin
      if (s >= 1)
        for (int j = 0; j < N1; j++)
          if (s1[j] && exp_cnt[j] < (1 << CB) - 1) exp_cnt[j]++;
      for (int n = 0; n < N0; n++) begin
        sum = 0;
        for (int i = 0; i < INPUTS; i++)
          if (m_in[i]) sum += m_w[n*INPUTS + i] ? 1 : -1;
        a = (v0[n] >> sh) + sum;
        if (a >= th0) begin ns0[n] = 1; v0[n] = 0; end
        else begin ns0[n] = 0; v0[n] = (a < 0) ? 0 : a; end
      end
      for (int j = 0; j < N1; j++) begin
        sum = 0;
        for (int k = 0; k < N0; k++)
          if (p[k]) sum += m_w[INPUTS*N0 + j*N0 + k] ? 1 : -1;
        a = (v1[j] >> sh) + sum;
        if (a >= th1) begin ns1[j] = 1; v1[j] = 0; end
        else begin ns1[j] = 0; v1[j] = (a < 0) ? 0 : a; end
      end
      for (int n = 0; n < N0; n++) begin p[n] = s0[n]; s0[n] = ns0[n]; end
      for (int j = 0; j < N1; j++) s1[j] = ns1[j];
    end
    for (int j = 0; j < N1; j++) exp_spk[j] = s1[j];
  endtask

  function automatic int exp_winner();
`ifdef SNN_ARGMAX_EN
    int b;
    b = 0;
    for (int j = 1; j < N1; j++) if (exp_cnt[j] > exp_cnt[b]) b = j;
    return b;
`else
    return 0;
`endif
  endfunction

  task automatic send(input logic [1:0] c, input logic [7:0] b);
    cmd = c;
    data_in = b;
    data_valid = 1'b1;
    #1;
    chk("ready_load", data_ready, 1);
    tick();
    data_valid = 1'b0;
    case (c)
      2'b00:   m_in  = {m_in[INPUTS-9:0], b};
      2'b01:   m_w   = {m_w[WB-9:0], b};
      2'b10:   m_cfg = {m_cfg[15:0], b};
      default: ;
    endcase
  endtask

  task automatic check_counts(input string tag);
    for (int j = 0; j < N1; j++) begin
      count_sel = SW'(j);
      #1;
      chk({tag, "_count"}, count_out, exp_cnt[j]);
    end
  endtask

  // Starts a run, measures the busy window, then checks results against the model
  task automatic run_check(input string tag, input bit junk);
    int len;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (junk) begin
      cmd = 2'b00;
      data_in = 8'hAA;
      data_valid = 1'b1;
    end
    len = 0;
    while (busy === 1'b1 && len < 40) begin
      start = (junk && len == 3);
      #1;
      chk({tag, "_ready_run"}, data_ready, 0);
      tick();
      len++;
      if (busy !== 1'b1) data_valid = 1'b0;
    end
    data_valid = 1'b0;
    start = 1'b0;
    chk({tag, "_busy_len"}, len, T + 1);
    chk({tag, "_done"}, done, 1);
    model_run();
    check_counts(tag);
    chk({tag, "_winner"}, winner, exp_winner());
    chk({tag, "_spikes"}, spikes, exp_spk);
  endtask

  initial begin
    logic [WB-1:0] tgt;
    int k;

    // 1. reset and idle
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    tick(); tick(); tick();
    chk("rst_ready", data_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_winner", winner, 0);
    chk("rst_spikes", spikes, 0);
    for (int j = 0; j < N1; j++) exp_cnt[j] = 0;
    check_counts("rst");

    // 2. zero inputs
    send(2'b00, 8'h00);
    send(2'b00, 8'h00);
    run_check("zero", 1'b0);

    // 3. all-ones inputs with reset weights and thresholds
    send(2'b00, 8'hFF);
    send(2'b00, 8'hFF);
    run_check("ones", 1'b0);
    chk("ones_count_nonzero", (exp_cnt[0] > 0), 1);

    // loading while DONE returns to IDLE and leaves counts frozen
    send(2'b01, 8'h5A);
    chk("done_load_done", done, 0);
    chk("done_load_busy", busy, 0);
    check_counts("done_load");

    // 4. output neuron 5 gets the strongest drive
    send(2'b10, 8'h01);
    send(2'b10, 8'h01);
    send(2'b10, 8'h00);
    send(2'b00, 8'h00);
    send(2'b00, 8'h01);
    tgt = '1;
    for (int j = 0; j < N1; j++)
      for (int kk = 0; kk < N0; kk++)
        tgt[INPUTS*N0 + j*N0 + kk] = (j == 5);
    for (int b = 0; b < WB/8; b++) send(2'b01, tgt[WB-1-8*b -: 8]);
    chk("drive_model_w", m_w, tgt);
    run_check("drive", 1'b0);
    count_sel = SW'(5);
    #1;
    chk("drive_count5", count_out, 6);

    // 5. bytes and start presented during a run are ignored
    send(2'b00, 8'h00);
    send(2'b00, 8'h00);
    run_check("junk", 1'b1);
    run_check("junk_rerun", 1'b0);

    // 6. reset in the middle of a run
    send(2'b00, 8'hFF);
    send(2'b00, 8'hFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", data_ready, 1);
    chk("midrst_spikes", spikes, 0);
    chk("midrst_winner", winner, 0);
    for (int j = 0; j < N1; j++) exp_cnt[j] = 0;
    check_counts("midrst");
    send(2'b00, 8'hFF);
    send(2'b00, 8'hFF);
    run_check("post_rst", 1'b0);

    // randomized configurations, inputs and weights
    for (int r = 0; r < 4; r++) begin
      send(2'b10, 8'($urandom_range(1, 10)));
      send(2'b10, 8'($urandom_range(1, 8)));
      k = int'($urandom_range(0, 3));
      send(2'b10, {5'($urandom), 3'(k)});
      send(2'b11, 8'($urandom));
      send(2'b00, 8'($urandom));
      send(2'b00, 8'($urandom));
      for (int b = 0; b < WB/8; b++) send(2'b01, 8'($urandom));
      run_check("rand", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
